// File: rtl/audio_dac_serializer_pkg.sv
// Shared constants and frame type for the audio DAC serializer slice.
package audio_pkg;

    localparam int   AUDIO_DATA_WIDTH = 32;
    localparam logic LRCK_LEFT        = 1'b1;

    typedef struct packed {
        logic [AUDIO_DATA_WIDTH-1:0] left;
        logic [AUDIO_DATA_WIDTH-1:0] right;
    } audio_frame_t;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo frame write port into the DAC serializer (valid/ready handshake).
interface audio_dac_serializer_if
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] left_channel_audio_in;
    logic [DATA_WIDTH-1:0] right_channel_audio_in;
    logic                  in_valid;
    logic                  in_ready;

    modport master (
        output left_channel_audio_in,
        output right_channel_audio_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  left_channel_audio_in,
        input  right_channel_audio_in,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/audio_dac_serializer_frame_fifo.sv
// Synchronous frame FIFO with registered level; depth must be a power of two.
module audio_frame_fifo
    import audio_pkg::*;
#(
    parameter type T     = audio_frame_t,
    parameter int  DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  T                      i_data,
    input  logic                  i_pop,
    output T                      o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_level;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_level == FULL_LEVEL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_data  = r_mem[r_rdPtr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LEVEL_ONE;
                2'b01:   r_level <= r_level - LEVEL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Buffers stereo frames and shifts them MSB-first onto AUD_DACDAT, left-justified to AUD_DACLRCK.
// Define AUDIO_DAC_I2S_DELAY_EN for I2S timing (DACDAT delayed one extra AUD_BCLK).
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = AUDIO_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                        AUD_BCLK,
    input  logic                        reset,
    input  logic                        AUD_DACLRCK,
    audio_dac_serializer_if.slave       bus,
    output logic                        AUD_DACDAT,
    output logic                        underrun,
    output logic [CNT_WIDTH-1:0]        underrun_count,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] left;
        logic [DATA_WIDTH-1:0] right;
    } frame_t;

    frame_t                w_inFrame;
    frame_t                w_headFrame;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_edge;
    logic                  w_frameStart;
    logic                  w_rightStart;
    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_loadData;

    logic                  r_lrckQ;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_dacBit;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_underrunCount;

    assign w_inFrame    = {bus.left_channel_audio_in, bus.right_channel_audio_in};
    assign bus.in_ready = !w_full;
    assign w_push       = bus.in_valid && !w_full;

    assign w_edge       = (AUD_DACLRCK != r_lrckQ);
    assign w_frameStart = w_edge && (AUD_DACLRCK == LRCK_LEFT);
    assign w_rightStart = w_edge && (AUD_DACLRCK != LRCK_LEFT);
    assign w_pop        = w_frameStart && !w_empty;

    audio_frame_fifo #(
        .T     (frame_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (AUD_BCLK),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_inFrame),
        .i_pop   (w_pop),
        .o_data  (w_headFrame),
        .o_level (fifo_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // An empty FIFO at frame start sends silence rather than stale data.
    always_comb begin
        w_load     = 1'b0;
        w_loadData = '0;
        if (w_frameStart) begin
            w_load     = 1'b1;
            w_loadData = w_empty ? '0 : w_headFrame.left;
        end else if (w_rightStart) begin
            w_load     = 1'b1;
            w_loadData = r_hold;
        end
    end

    // The MSB goes straight to the output register so it appears the cycle after the edge.
    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            r_lrckQ  <= AUD_DACLRCK;
            r_shift  <= '0;
            r_hold   <= '0;
            r_dacBit <= 1'b0;
        end else begin
            r_lrckQ <= AUD_DACLRCK;
            if (w_frameStart) begin
                r_hold <= w_empty ? '0 : w_headFrame.right;
            end
            if (w_load) begin
                r_dacBit <= w_loadData[DATA_WIDTH-1];
                r_shift  <= {w_loadData[DATA_WIDTH-2:0], 1'b0};
            end else begin
                r_dacBit <= r_shift[DATA_WIDTH-1];
                r_shift  <= {r_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            r_underrun      <= 1'b0;
            r_underrunCount <= '0;
        end else begin
            r_underrun <= w_frameStart && w_empty;
            if (w_frameStart && w_empty && (r_underrunCount != '1)) begin
                r_underrunCount <= r_underrunCount + CNT_ONE;
            end
        end
    end

    assign underrun       = r_underrun;
    assign underrun_count = r_underrunCount;

`ifdef AUDIO_DAC_I2S_DELAY_EN
    logic r_i2sDelay;

    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            r_i2sDelay <= 1'b0;
        end else begin
            r_i2sDelay <= r_dacBit;
        end
    end

    assign AUD_DACDAT = r_i2sDelay;
`else
    assign AUD_DACDAT = r_dacBit;
`endif

endmodule
